// File: rtl/pipe_skid_buffer_pkg.sv
// Package: pipe_skid_buffer_pkg
// Purpose: shared state encodings for the skid-buffer pipeline stage.
//   PIPE_EMPTY / PIPE_BUSY / PIPE_FULL double as the occupancy count (0/1/2),
//   so the count output is the state register itself.
package pipe_skid_buffer_pkg;

    localparam logic [1:0] PIPE_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_BUSY  = 2'd1;
    localparam logic [1:0] PIPE_FULL  = 2'd2;

    // True when the encoding holds a beat in the main entry.
    function automatic logic state_has_beat(input logic [1:0] s);
        return s != PIPE_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// Interface: pipe_skid_buffer_if
// Purpose: bundles the upstream and downstream handshakes of pipe_skid_buffer.
//   Handshake rule (both sides): a beat transfers on a posedge where valid
//   and ready are both high; a producer holding valid keeps its data stable
//   until the transfer; ready never depends combinationally on valid.
// Signals:
//   in_valid/in_ready/in_data     upstream side
//   out_valid/out_ready/out_data  downstream side
//   count                         occupancy 0..2
//   flush                         present only with PIPE_SKID_FLUSH_EN defined
// Modports:
//   slave  - the buffer itself
//   master - the environment driving both ends
interface pipe_skid_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;
`ifdef PIPE_SKID_FLUSH_EN
    logic             flush;
`endif

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef PIPE_SKID_FLUSH_EN
        input  flush,
`endif
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, out_ready,
`ifdef PIPE_SKID_FLUSH_EN
        output flush,
`endif
        input  in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_skid_buffer_reg_rst_ce.sv
// Module: reg_rst_ce
// Purpose: N-bit register with synchronous active-high reset and clock enable.
//   Holds its value whenever ce is low, so data only moves on real loads.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset, loads RESET_VAL
//   ce   in  1  load enable
//   d    in  N  next value
//   q    out N  current value
module reg_rst_ce #(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (ce) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Module: pipe_skid_buffer
// Purpose: two-entry elastic pipeline stage (main + skid). in_ready comes
//   from the state register only, so it never depends on out_ready
//   combinationally. Full throughput, one cycle latency, strict FIFO order.
// Optional feature: define PIPE_SKID_FLUSH_EN to add the flush input, which
//   drops every held beat (rst > flush > handshake); data regs keep contents.
// Ports:
//   clk        in   1   clock
//   rst        in   1   synchronous active-high reset
//   bus        slave modport of pipe_skid_buffer_if (handshakes, count, flush)
//   dbg_state  out  2   current FSM state for observation
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_skid_buffer_if.slave     bus,
    output logic [1:0]            dbg_state
);
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             in_fire;
    logic             out_fire;
    logic             flush_req;
    logic             main_ce;
    logic             skid_ce;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    assign bus.in_ready  = (state_q != PIPE_FULL) && !flush_req;
    assign bus.out_valid = state_has_beat(state_q);
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;
    assign dbg_state     = state_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_ce = 1'b0;
        main_d  = bus.in_data;
        skid_ce = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (in_fire) begin
                    main_ce = 1'b1;
                    state_d = PIPE_BUSY;
                end
            end
            PIPE_BUSY: begin
                if (in_fire && out_fire) begin
                    main_ce = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled: park the new beat behind main.
                    skid_ce = 1'b1;
                    state_d = PIPE_FULL;
                end else if (out_fire) begin
                    state_d = PIPE_EMPTY;
                end
            end
            PIPE_FULL: begin
                if (out_fire) begin
                    // Older skid beat moves up; in_ready was low so nothing new.
                    main_ce = 1'b1;
                    main_d  = skid_q;
                    state_d = PIPE_BUSY;
                end
            end
            default: state_d = PIPE_EMPTY;
        endcase
        if (flush_req) begin
            state_d = PIPE_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    reg_rst_ce #(.N(WIDTH), .RESET_VAL(RESET_DATA)) u_main (
        .clk (clk),
        .rst (rst),
        .ce  (main_ce),
        .d   (main_d),
        .q   (main_q)
    );

    reg_rst_ce #(.N(WIDTH), .RESET_VAL(RESET_DATA)) u_skid (
        .clk (clk),
        .rst (rst),
        .ce  (skid_ce),
        .d   (bus.in_data),
        .q   (skid_q)
    );

endmodule
